keypad_scanner: RTL

Matrix-scan front end for the 3-column x 4-row phone keypad. It drives the columns, samples the rows, debounces, and encodes each press as a 4-bit code. It issues a one-cycle strobe on key_valid, which feeds the keypad_input / keypad_input_enable pair of the downstream keypad latch. Code 0 is reserved for "no key", so every emitted code is 1..12.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_scan_timer.sv | 32 +++
 rtl/keypad_scanner.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 3x4 keypad scanner.
//   - Scanner state encoding (SCAN, DEBOUNCE, HELD)
//   - Reserved / special key codes
//   - Matrix dimensions
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t HELD     = 2'd2;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_ZERO = 4'd11;
    localparam logic [3:0] KEY_HASH = 4'd12;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;

endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: free-running 0..SCAN_DIV-1 slot counter.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high
//   tick  - high for one cycle while the counter sits at SCAN_DIV-1
module keypad_scan_timer #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + ONE;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scan, debounce and encode for a 3-column x 4-row keypad.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high
//   row_in    - rows, active-low, already synchronised
//   col_out   - column drive, active-low, exactly one bit low
//   key_code  - last accepted code (1..12), 0 after reset
//   key_valid - one-cycle strobe in the cycle key_code updates
//   key_held  - high from the strobe until the release is accepted
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam int unsigned CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    // Count value held just before the final accepting sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             tick;
    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d, col_next;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             accept;

    logic [2:0] low_cnt;
    logic [1:0] hit_row;
    logic       hit;
    logic [3:0] sample_code;

    keypad_scan_timer #(
        .SCAN_DIV(SCAN_DIV)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // A sample is a hit only when exactly one row is pulled low.
    always_comb begin
        low_cnt = '0;
        hit_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_in[r]) begin
                low_cnt = low_cnt + 3'd1;
                hit_row = 2'(r);
            end
        end
    end

    assign hit         = (low_cnt == 3'd1);
    assign sample_code = {2'b00, hit_row} * 4'd3 + {2'b00, col_q} + 4'd1;
    assign col_next    = (col_q == 2'(NUM_COLS - 1)) ? 2'd0 : col_q + 2'd1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        accept  = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        cand_d  = sample_code;
                        cnt_d   = CNT_ONE;
                        state_d = DEBOUNCE;
                        accept  = (DEBOUNCE_CNT == 1);
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (hit && (sample_code == cand_q)) begin
                        cnt_d  = cnt_q + CNT_ONE;
                        accept = (cnt_q == CNT_LAST);
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        col_d   = col_next;
                    end
                end
                HELD: begin
                    // Any low row, even from a different key, restarts the release count.
                    if (row_in == 4'hF) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            held_d  = 1'b0;
                            state_d = SCAN;
                            col_d   = col_next;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end

        if (accept) begin
            code_d  = cand_d;
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            cand_q  <= KEY_NONE;
            cnt_q   <= '0;
            code_q  <= KEY_NONE;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        case (col_q)
            2'd1:    col_out = 3'b101;
            2'd2:    col_out = 3'b011;
            default: col_out = 3'b110;
        endcase
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
